// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and lane-index type for the 1-to-8 demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1_to_8_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec_3to8
// Description : Combinational 3-to-8 one-hot decoder with enable. All-zero
//               output when disabled, so it directly forms the next lane-valid.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec_3to8
  import demux_pkg::*;
(
  input  lane_sel_t          sel_i,
  input  logic               en_i,
  output logic [N_LANES-1:0] onehot_o
);

  // Set exactly the selected bit when enabled, otherwise nothing
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule : onehot_dec_3to8
`default_nettype wire

// File: rtl/demux_1_to_8.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_8
// Description : Registered 1-to-8 demultiplexer. Steers the input word to the
//               selected lane, zeroes every other lane, and flags the active
//               lane with a one-hot valid. One cycle latency, no back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_to_8
  import demux_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         in,
  input  lane_sel_t             sel,
  input  logic                  in_valid,
  output logic [N_LANES*DW-1:0] out,
  output logic [N_LANES-1:0]    out_valid
);

  logic [N_LANES-1:0]    dec_w;
  logic [N_LANES*DW-1:0] out_d;
  logic [N_LANES-1:0]    out_valid_d;
  logic [N_LANES*DW-1:0] out_q;
  logic [N_LANES-1:0]    out_valid_q;

  // The decoder output is zero when in_valid is low, which clears every lane
  // and the valid vector in the same stroke -- no stale data survives.
  onehot_dec_3to8 u_dec (
    .sel_i    (sel),
    .en_i     (in_valid),
    .onehot_o (dec_w)
  );

  assign out_valid_d = dec_w;

  // Per-lane AND gating: each lane passes the input only when its decode bit is set
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign out_d[k*DW +: DW] = in & {DW{dec_w[k]}};
  end

  // Output register bank; asynchronous reset clears outputs without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule : demux_1_to_8
`default_nettype wire

// File: tb/tb_demux_1_to_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_to_8
// Description : Directed and random self-checking bench for demux_1_to_8,
//               with one DW=1 and one DW=8 instance sharing sel/in_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_to_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in1;
  logic [7:0]  in8;
  logic [2:0]  sel;
  logic        in_valid;
  logic [7:0]  out1;
  logic [7:0]  out_valid1;
  logic [63:0] out8;
  logic [7:0]  out_valid8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_1_to_8 #(.DW(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in        (in1),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out1),
    .out_valid (out_valid1)
  );

  demux_1_to_8 #(.DW(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in        (in8),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out8),
    .out_valid (out_valid8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, then sample #1 after the capturing edge
  task automatic drive(input logic v, input logic [2:0] s, input logic d1, input logic [7:0] d8);
    in_valid = v;
    sel      = s;
    in1      = d1;
    in8      = d8;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp8;
    logic [7:0]  exp1;
    logic [7:0]  expv;
    logic        rv;
    logic [2:0]  rs;
    logic        r1;
    logic [7:0]  r8;

    rst = 1'b1; in_valid = 1'b0; sel = 3'd0; in1 = 1'b0; in8 = 8'h00;
    #2;
    check("reset_out1",  {56'd0, out1},       64'd0);
    check("reset_vld1",  {56'd0, out_valid1}, 64'd0);
    check("reset_out8",  out8,                64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // DW=1: step sel through all lanes
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b1, 8'h00);
      exp1 = 8'h01 << i;
      check($sformatf("step_out_%0d", i), {56'd0, out1},       {56'd0, exp1});
      check($sformatf("step_vld_%0d", i), {56'd0, out_valid1}, {56'd0, exp1});
    end

    // Routed zero is distinguished by out_valid
    drive(1'b1, 3'd5, 1'b0, 8'h00);
    check("zero_out1", {56'd0, out1},       64'd0);
    check("zero_vld1", {56'd0, out_valid1}, 64'h20);

    // DW=8 back-to-back words to different lanes
    drive(1'b1, 3'd3, 1'b0, 8'hA5);
    check("w8_a_out", out8,                64'h0000_0000_A500_0000);
    check("w8_a_vld", {56'd0, out_valid8}, 64'h08);
    drive(1'b1, 3'd6, 1'b0, 8'h3C);
    check("w8_b_out", out8,                64'h003C_0000_0000_0000);
    check("w8_b_vld", {56'd0, out_valid8}, 64'h40);

    // Idle cycle clears everything
    drive(1'b1, 3'd2, 1'b1, 8'h00);
    check("pre_idle_out1", {56'd0, out1}, 64'h04);
    drive(1'b0, 3'd2, 1'b1, 8'hFF);
    check("idle_out1", {56'd0, out1},       64'd0);
    check("idle_vld1", {56'd0, out_valid1}, 64'd0);
    check("idle_out8", out8,                64'd0);

    // Asynchronous reset mid-stream
    drive(1'b1, 3'd7, 1'b1, 8'h99);
    check("pre_rst_vld", {56'd0, out_valid1}, 64'h80);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out1", {56'd0, out1},       64'd0);
    check("async_rst_vld1", {56'd0, out_valid1}, 64'd0);
    check("async_rst_out8", out8,                64'd0);
    @(posedge clk); #1;
    check("rst_hold_vld8", {56'd0, out_valid8}, 64'd0);
    check("rst_hold_out8", out8,                64'd0);
    #2;
    rst = 1'b0;
    drive(1'b1, 3'd1, 1'b1, 8'h5A);
    check("post_rst_out8", out8,                64'h0000_0000_0000_5A00);
    check("post_rst_vld8", {56'd0, out_valid8}, 64'h02);

    // Random traffic against a lane-by-lane reference
    for (int c = 0; c < 1000; c++) begin
      rv = 1'($urandom_range(0, 3) != 0);
      rs = 3'($urandom_range(0, 7));
      r1 = 1'($urandom_range(0, 1));
      r8 = 8'($urandom_range(0, 255));
      exp8 = 64'd0;
      exp1 = 8'd0;
      expv = 8'd0;
      for (int k = 0; k < 8; k++) begin
        if (rv && (rs == 3'(k))) begin
          exp8[k*8 +: 8] = r8;
          exp1[k]        = r1;
          expv[k]        = 1'b1;
        end
      end
      drive(rv, rs, r1, r8);
      check("rnd_out8",    out8,                   exp8);
      check("rnd_vld8",    {56'd0, out_valid8},    {56'd0, expv});
      check("rnd_out1",    {56'd0, out1},          {56'd0, exp1});
      check("rnd_onehot0", {63'd0, $onehot0(out_valid1)}, 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux_1_to_8
`default_nettype wire
